// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared constants and helpers for the three-stage valid/ready pipeline.
//   DATA_W_DEF : default data word width
//   DEPTH      : number of pipeline stages (the control logic is written for 3)
//   OCC_W      : width of the occupancy count (0..DEPTH)
//   CNT_W      : width of the output handshake counter
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH      = 3;
   localparam int OCC_W      = 2;
   localparam int CNT_W      = 16;

   typedef logic [OCC_W-1:0] occ_t;
   typedef logic [CNT_W-1:0] cnt_t;

   // Number of set valid bits across the stages.
   function automatic occ_t count_valid(input logic [DEPTH-1:0] v);
      occ_t c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         c = c + occ_t'(v[i]);
      end
      return c;
   endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//   One pipeline slot: a valid bit plus a data register.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and data)
//   load       : capture d_in and mark the slot valid
//   clear      : mark the slot empty; wins over load
//   d_in       : incoming data word
//   vld, data  : registered slot contents
// ---------------------------------------------------------------------------
module pipe_stage #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_in,
   output logic              vld,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         data <= '0;
      end else begin
         if (clear)     vld <= 1'b0;
         else if (load) vld <= 1'b1;
         if (load)      data <= d_in;
      end
   end

endmodule : pipe_stage

// File: rtl/pipe3_ctrl.sv
// ---------------------------------------------------------------------------
// pipe3_ctrl
//   Three-stage valid/ready pipeline with bubble collapse, synchronous flush,
//   occupancy reporting and a wrapping output handshake counter.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : producer handshake, in_data is the offered word
//   out_valid/out_ready  : consumer handshake, out_data is the stage-3 word
//   flush                : drop every in-flight word at the next edge
//   occupancy            : number of valid stages
//   xfer_count           : completed output handshakes, wraps at 2^16
// ---------------------------------------------------------------------------
module pipe3_ctrl
   import pipe_pkg::*;
#(
   parameter int DATA_W = pipe_pkg::DATA_W_DEF,
   parameter int DEPTH  = pipe_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [OCC_W-1:0]  occupancy,
   output logic [CNT_W-1:0]  xfer_count
);

   // Index 0 is stage 1 (input side), index DEPTH-1 is stage 3 (output side).
   logic [DEPTH-1:0]             v;
   logic [DEPTH-1:0]             load;
   logic [DEPTH-1:0]             clear;
   logic [DEPTH-1:0][DATA_W-1:0] d;
   logic [DEPTH-1:0][DATA_W-1:0] d_in;

   logic adv3, adv2, adv1;
   logic mv2, mv1;
   logic in_hs, out_hs;

   // Advance chain, resolved from the output side backwards: a stage is free
   // next cycle if it is empty or its word moves on this cycle.
   assign adv3 = ~v[2] | out_ready;
   assign mv2  = v[1] & adv3;
   assign adv2 = ~v[1] | mv2;
   assign mv1  = v[0] & adv2;
   assign adv1 = ~v[0] | mv1;

   // Gated by rst_n so the producer sees "not ready" while reset is held.
   assign in_ready = adv1 & ~flush & rst_n;
   assign in_hs    = in_valid & in_ready;
   assign out_hs   = v[2] & out_ready;

   // A stage empties when its word leaves and nothing replaces it; flush
   // empties everything, though the stage-3 word still counts if taken.
   assign load[0]  = in_hs;
   assign load[1]  = mv1 & ~flush;
   assign load[2]  = mv2 & ~flush;
   assign clear[0] = flush | (mv1    & ~in_hs);
   assign clear[1] = flush | (mv2    & ~mv1);
   assign clear[2] = flush | (out_hs & ~mv2);

   assign d_in[0] = in_data;

   for (genvar s = 1; s < DEPTH; s++) begin : g_link
      assign d_in[s] = d[s-1];
   end

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      pipe_stage #(.DATA_W(DATA_W)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[s]),
         .clear (clear[s]),
         .d_in  (d_in[s]),
         .vld   (v[s]),
         .data  (d[s])
      );
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign occupancy = count_valid(v);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      xfer_count <= '0;
      else if (out_hs) xfer_count <= xfer_count + 1'b1;
   end

endmodule : pipe3_ctrl

// File: tb/tb_pipe3_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe3_ctrl
//   Scoreboard bench: the driver pushes accepted words into sb_q and a
//   monitor pops/compares on every output handshake. A position-based model
//   (each word climbs one stage per cycle, capped just behind the word ahead)
//   predicts in_ready, out_valid, out_data, occupancy and xfer_count.
// ---------------------------------------------------------------------------
module tb_pipe3_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        flush = 1'b0;
   logic [1:0]  occupancy;
   logic [15:0] xfer_count;

   pipe3_ctrl #(.DATA_W(8), .DEPTH(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .flush      (flush),
      .occupancy  (occupancy),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         pos;   // 1..3, stage currently holding the word
   } word_t;

   word_t      mq[$];     // model pipeline contents, oldest first
   logic [7:0] sb_q[$];   // scoreboard of words expected at the output
   logic [7:0] tx_q[$];   // words waiting to be offered
   logic [15:0] mcnt = '0;
   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, compare at +1, update model at posedge.
   task automatic cycle(input bit ordy, input bit fl, input bit want_v);
      bit         iv, exp_rdy, exp_ov, acc, hs;
      logic [7:0] id;
      int         lim, np;
      @(negedge clk);
      iv = want_v && (tx_q.size() > 0);
      id = iv ? tx_q[0] : 8'($urandom);
      in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
      #1;
      exp_rdy = !fl && (mq.size() < 3 || ordy);
      exp_ov  = (mq.size() > 0) && (mq[0].pos == 3);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) chk("out_data", 32'(out_data), 32'(mq[0].data));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("xfer_count", 32'(xfer_count), 32'(mcnt));
      acc = iv && exp_rdy;
      hs  = exp_ov && ordy;
      @(posedge clk);
      if (hs) begin
         void'(mq.pop_front());
         mcnt = mcnt + 16'd1;
      end
      if (fl) begin
         mq.delete();
         sb_q.delete();
      end else begin
         for (int i = 0; i < mq.size(); i++) begin
            lim = (i == 0) ? 3 : mq[i-1].pos - 1;
            np  = mq[i].pos + 1;
            mq[i].pos = (np > lim) ? lim : np;
         end
      end
      if (acc) begin
         mq.push_back('{data: id, pos: 1});
         sb_q.push_back(id);
         void'(tx_q.pop_front());
      end
   endtask

   // Reset asserted between edges; outputs must clear with no clock edge.
   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_xfer_count", 32'(xfer_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      mq.delete(); sb_q.delete(); tx_q.delete();
      mcnt = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   // Monitor: compare every output handshake against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL sb_underflow: got %0h expected none", out_data);
            end else begin
               chk("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #2;
      async_reset();

      // Streaming 11,22,33,44 with out_ready high.
      tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 8; i++) cycle(1, 0, 1);
      #2 chk("stream_cnt", 32'(xfer_count), 32'd4);

      // Backpressure: five offered, three accepted, then drain.
      tx_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      for (int i = 0; i < 6; i++) cycle(0, 0, 1);
      #2 chk("bp_out_data", 32'(out_data), 32'hA1);
      chk("bp_occ", 32'(occupancy), 32'd3);
      tx_q.delete();
      for (int i = 0; i < 5; i++) cycle(1, 0, 0);
      #2 chk("bp_drain_cnt", 32'(xfer_count), 32'd7);

      // Bubble collapse: A, idle, B with out_ready low.
      tx_q = '{8'h5A};
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      tx_q.push_back(8'hB5);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1);
      #2 chk("bubble_occ", 32'(occupancy), 32'd2);
      chk("bubble_head", 32'(out_data), 32'h5A);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0);

      // Flush a full pipe with out_ready high; word in flight stays offered.
      tx_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      for (int i = 0; i < 4; i++) cycle(0, 0, 1);
      cycle(1, 1, 1);
      #2 chk("flush_cnt", 32'(xfer_count), 32'd10);
      chk("flush_occ", 32'(occupancy), 32'd0);
      for (int i = 0; i < 4; i++) cycle(1, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if (tx_q.size() < 4) tx_q.push_back(8'($urandom));
         cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 40) == 0),
               bit'($urandom_range(0, 3) != 0));
      end

      // Reset mid-stream, then accept right away.
      tx_q = '{8'hE1, 8'hE2, 8'hE3};
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      async_reset();
      tx_q = '{8'hF0};
      for (int i = 0; i < 4; i++) cycle(1, 0, 1);
      #2 chk("post_rst_cnt", 32'(xfer_count), 32'd1);

      // Counter wrap.
      async_reset();
      for (int i = 0; i < 65600 && mcnt != 16'hFFFF; i++) begin
         tx_q.push_back(8'($urandom));
         cycle(1, 0, 1);
      end
      #2 chk("cnt_ffff", 32'(xfer_count), 32'hFFFF);
      cycle(1, 0, 1);
      #2 chk("cnt_wrap", 32'(xfer_count), 32'h0000);
      tx_q.delete();
      for (int i = 0; i < 5; i++) cycle(1, 0, 0);
      #2 chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_pipe3_ctrl
